// File: rtl/input_debounce_2ch_pkg.sv
// Shared definitions for the two-channel input debouncer: FSM state encoding
// and default parameter values.
package input_debounce_2ch_pkg;

  localparam int unsigned CNT_W_DEF           = 16;
  localparam int unsigned DEBOUNCE_CYCLES_DEF = 50000;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } state_e;

endpackage

// File: rtl/input_debounce_2ch_debounce_ch.sv
// One debounce channel: two-flop synchronizer, STABLE/COUNTING FSM with a
// run-length counter, debounced level and single-cycle rise/fall pulses.
module debounce_ch
  import input_debounce_2ch_pkg::*;
#(
  parameter int unsigned CNT_W           = CNT_W_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic raw_in,
  output logic level_out,
  output logic rise_out,
  output logic fall_out,
  output logic stable_c
);

  if (DEBOUNCE_CYCLES < 2 || 64'(DEBOUNCE_CYCLES) > ((64'd1 << CNT_W) - 64'd1)) begin : g_bad_param
    $error("debounce_ch: DEBOUNCE_CYCLES out of range for CNT_W");
  end

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;

  // Next-state: only the second sync stage feeds the FSM.
  always_comb begin
    sync1_d = raw_in;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      ST_STABLE: begin
        if (sync2_q != level_q) begin
          state_d = ST_COUNTING;
          cnt_d   = CNT_W'(1);
        end else begin
          cnt_d = '0;
        end
      end
      ST_COUNTING: begin
        if (sync2_q == level_q) begin
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST_CNT) begin
          // Run long enough: commit the new level and flag the edge.
          level_d = sync2_q;
          rise_d  = sync2_q;
          fall_d  = ~sync2_q;
          state_d = ST_STABLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
    endcase
    stable_c = (state_d == ST_STABLE);
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= ST_STABLE;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
    end
  end

  assign level_out = level_q;
  assign rise_out  = rise_q;
  assign fall_out  = fall_q;

endmodule

// File: rtl/input_debounce_2ch.sv
// Two independent debounce channels feeding the downstream AND stage, plus a
// registered flag that is high when neither channel is mid-count.
module input_debounce_2ch
  import input_debounce_2ch_pkg::*;
#(
  parameter int unsigned CNT_W           = CNT_W_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk_in,
  input  logic rst_n_in,
  input  logic a_raw_in,
  input  logic b_raw_in,
  output logic a_out,
  output logic b_out,
  output logic a_rise_out,
  output logic a_fall_out,
  output logic b_rise_out,
  output logic b_fall_out,
  output logic stable_out
);

  logic a_stable_c;
  logic b_stable_c;
  logic stable_q, stable_d;

  debounce_ch #(
    .CNT_W          (CNT_W),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_ch_a (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .raw_in   (a_raw_in),
    .level_out(a_out),
    .rise_out (a_rise_out),
    .fall_out (a_fall_out),
    .stable_c (a_stable_c)
  );

  debounce_ch #(
    .CNT_W          (CNT_W),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_ch_b (
    .clk_in   (clk_in),
    .rst_n_in (rst_n_in),
    .raw_in   (b_raw_in),
    .level_out(b_out),
    .rise_out (b_rise_out),
    .fall_out (b_fall_out),
    .stable_c (b_stable_c)
  );

  // Registered from the channels' next-state so it tracks their state flops.
  always_comb begin
    stable_d = a_stable_c & b_stable_c;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      stable_q <= 1'b1;
    end else begin
      stable_q <= stable_d;
    end
  end

  assign stable_out = stable_q;

endmodule

// File: tb/tb_input_debounce_2ch.sv
// Scoreboard bench for input_debounce_2ch: a run-length reference model pushes
// the expected outputs of every edge; a monitor pops and compares after it.
module tb_input_debounce_2ch;

  localparam int unsigned D = 4;
  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic rst_n, a_raw, b_raw;
  logic a_out, b_out, a_rise, a_fall, b_rise, b_fall, stable;

  always #5 clk = ~clk;

  input_debounce_2ch #(
    .CNT_W          (W),
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk_in    (clk),
    .rst_n_in  (rst_n),
    .a_raw_in  (a_raw),
    .b_raw_in  (b_raw),
    .a_out     (a_out),
    .b_out     (b_out),
    .a_rise_out(a_rise),
    .a_fall_out(a_fall),
    .b_rise_out(b_rise),
    .b_fall_out(b_fall),
    .stable_out(stable)
  );

  int errors = 0;
  int checks = 0;
  logic [6:0] exp_q[$];

  // Reference model: two-edge input delay, then the level flips once the
  // delayed input has disagreed with it for D consecutive edges.
  logic s1a, s2a, lva, s1b, s2b, lvb;
  int   run_a, run_b;

  task automatic step_ch(input logic s2, inout logic lv, inout int run,
                         output logic r, output logic f);
    r = 1'b0;
    f = 1'b0;
    if (s2 != lv) begin
      run++;
      if (run == int'(D)) begin
        lv  = s2;
        r   = s2;
        f   = ~s2;
        run = 0;
      end
    end else begin
      run = 0;
    end
  endtask

  always @(posedge clk) begin : model
    logic ra, fa, rb, fb;
    if (!rst_n) begin
      s1a = 0; s2a = 0; lva = 0; run_a = 0;
      s1b = 0; s2b = 0; lvb = 0; run_b = 0;
      exp_q.push_back(7'b0000001);
    end else begin
      step_ch(s2a, lva, run_a, ra, fa);
      step_ch(s2b, lvb, run_b, rb, fb);
      s2a = s1a; s1a = a_raw;
      s2b = s1b; s1b = b_raw;
      exp_q.push_back({lva, lvb, ra, fa, rb, fb, (run_a == 0 && run_b == 0)});
    end
  end

  always @(posedge clk) begin : monitor
    logic [6:0] e, got;
    #1;
    got = {a_out, b_out, a_rise, a_fall, b_rise, b_fall, stable};
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL scoreboard_empty t=%0t got=%b", $time, got);
    end else begin
      e = exp_q.pop_front();
      if (got !== e) begin
        errors++;
        $display("FAIL outputs t=%0t got {a,b,ar,af,br,bf,st}=%b exp=%b", $time, got, e);
      end
    end
  end

  // Counts edges until the debounced output(s) reach val; expects exactly D+2.
  task automatic expect_latency(input string name, input bit chk_b, input logic val);
    int n = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk);
      #2;
      if (a_out === val && (!chk_b || b_out === val)) begin
        n = i;
        break;
      end
    end
    checks++;
    if (n != int'(D) + 2) begin
      errors++;
      $display("FAIL latency_%s edges=%0d exp=%0d", name, n, D + 2);
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    a_raw = 1'b1;
    b_raw = 1'b1;
    idle(3);
    rst_n = 1'b1;
    expect_latency("reset_release", 1'b1, 1'b1);
    idle(5);

    a_raw = 1'b0; b_raw = 1'b0;
    idle(10);

    a_raw = 1'b1;
    expect_latency("clean_step", 1'b0, 1'b1);
    idle(3);
    a_raw = 1'b0;
    idle(10);

    a_raw = 1'b1;
    idle(3);
    a_raw = 1'b0;
    idle(10);
    checks++;
    if (a_out !== 1'b0) begin
      errors++;
      $display("FAIL glitch_level got=%b exp=0", a_out);
    end

    a_raw = 1'b1; idle(1);
    a_raw = 1'b0; idle(1);
    a_raw = 1'b1; idle(1);
    a_raw = 1'b0; idle(1);
    a_raw = 1'b1;
    expect_latency("bounce", 1'b0, 1'b1);
    idle(3);

    a_raw = 1'b0; b_raw = 1'b0;
    idle(10);
    a_raw = 1'b1; b_raw = 1'b1;
    expect_latency("both_rise", 1'b1, 1'b1);
    idle(3);
    a_raw = 1'b0;
    expect_latency("a_fall", 1'b0, 1'b0);
    idle(3);

    a_raw = 1'b0; b_raw = 1'b0;
    idle(10);
    a_raw = 1'b1;
    idle(3);
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    expect_latency("after_mid_reset", 1'b0, 1'b1);
    idle(3);

    for (int i = 0; i < 300; i++) begin
      a_raw = 1'($urandom_range(0, 1));
      b_raw = 1'($urandom_range(0, 1));
      rst_n = ($urandom_range(0, 49) != 0);
      idle($urandom_range(1, 8));
    end

    rst_n = 1'b1;
    idle(3);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
